hyperbus_trans_sched: RTL and testbench
=======================================

Name: hyperbus_trans_sched

Overview:
- Transaction scheduler between the AXI slave channels and the HyperBus PHY transaction port.
- Arbitrates AW vs AR round-robin and latches one command at a time.
- Issues that command to the PHY, then sequences its data phase: W→TX gating with a beat counter, or RX→R with generated r_last.
- Produces the single B response per write and carries ID and error status.
- Sits between the AXI slave port and the TX/RX CDC FIFOs.

Parameters:
- BURST_WIDTH, 12, width of trans_burst_o (must be ≥9).
- ID_WIDTH, 4, AXI ID width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active high
- aw_valid_i / aw_ready_o  in/out  1  write address handshake
- aw_addr_i  in  32  write address
- aw_len_i  in  8  AXI len (beats-1)
- aw_burst_i  in  2  AXI burst type
- aw_id_i  in  ID_WIDTH  write ID
- ar_valid_i / ar_ready_o, ar_addr_i, ar_len_i, ar_burst_i, ar_id_i  same widths as AW, read channel
- w_valid_i / w_ready_o  in/out  1  write data handshake
- w_last_i  in  1  AXI w_last (checked only)
- tx_valid_o / tx_ready_i  out/in  1  TX FIFO handshake
- rx_valid_i / rx_ready_o  in/out  1  RX FIFO handshake
- r_valid_o / r_ready_i  out/in  1  AXI R handshake
- r_last_o  out  1  generated last
- r_id_o  out  ID_WIDTH  latched ID
- r_resp_o  out  2  OKAY/SLVERR
- b_valid_o / b_ready_i  out/in  1  write response handshake
- b_id_o  out  ID_WIDTH  latched ID
- b_resp_o  out  2  OKAY/SLVERR
- trans_valid_o / trans_ready_i  out/in  1  PHY command handshake
- trans_address_o  out  32  latched address
- trans_write_o  out  1  1 = write
- trans_burst_o  out  BURST_WIDTH  len+1, zero-extended
- trans_burst_type_o  out  1  axburst[0] (1 = linear, 0 = wrapped)
- trans_address_space_o  out  1  addr[31] (register space)
- trans_error_i  in  1  PHY error strobe
- busy_o  out  1  state ≠ IDLE

Behaviour:
- Reset (async, rst_i=1): state IDLE, all valid/ready outputs 0, latched fields 0, last_was_write=0, err flag 0, beat counter 0.
- States: IDLE, ISSUE, WDATA, WRESP, RDATA.
- IDLE arbitration:
  - If only one of aw_valid_i/ar_valid_i is high, grant it.
  - If both are high, grant the opposite of last_was_write (read wins the first tie after reset).
  - Combinationally assert the granted ax_ready_o in the same cycle; latch addr, len, burst, id and dir; update last_was_write; go to ISSUE.
  - The loser's ready stays 0.
- ISSUE:
  - trans_valid_o=1 from registered fields; fields stable until trans_ready_i.
  - On handshake: go to WDATA if write, else RDATA; clear counter and err flag.
- WDATA:
  - tx_valid_o = w_valid_i, w_ready_o = tx_ready_i; a beat counts on w_valid_i & w_ready_o.
  - On the beat where counter==len: go to WRESP.
  - If w_last_i mismatches (counter==len) on a counted beat, set err.
- RDATA:
  - r_valid_o = rx_valid_i, rx_ready_o = r_ready_i; r_last_o = (counter==len) & r_valid_o.
  - Beat counts on rx_valid_i & r_ready_i; the final beat returns to IDLE.
- trans_error_i in WDATA/RDATA/ISSUE-after-handshake sets sticky err (cleared on next ISSUE handshake).
- Error handling:
  - In WDATA with err set: tx_valid_o forced 0, w_ready_o=1 (drain) until the last counted beat.
  - In RDATA with err: r_resp_o=2'b10 for the remaining beats; data still passes.
- WRESP: b_valid_o=1, b_id_o latched, b_resp_o = err ? 2'b10 : 2'b00; on b_ready_i go to IDLE.
- r_id_o, r_resp_o are valid only while r_valid_o; otherwise 0.
- No new arbitration until IDLE. No outstanding transactions, single in-flight command.
- Counter is 8 bits; len=255 gives 256 beats with no wrap before last.
- Reset mid-burst aborts silently; FIFOs are the owner's responsibility.

Decomposition:
- Package hyperbus_pkg:
  - Enum hyper_sched_state_t.
  - Constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
  - Struct hyper_cmd_t {addr, len, burst, id, write}.
- One sub-module is natural: hyperbus_rr_arb2, a 2-way round-robin arbiter with a last-grant flop.

Test Plan:
- Single write: aw_len=3, addr 0x0000_1000 → one trans (write=1, burst=4, space=0), exactly 4 TX beats, b_resp=00, b_id echoed.
- Simultaneous AW and AR after reset → read granted first, write second; a repeated tie alternates.
- Read len=0 addr 0x8000_0004 → trans_address_space_o=1, burst=1, a single R beat with r_last_o=1.
- trans_error_i pulsed mid-write of 8 beats → remaining W beats are drained with tx_valid_o=0, and b_resp=10.
- Read of 4 beats with r_ready_i toggled every cycle → r_last_o only on the 4th accepted beat, and no beat is lost.
- rst_i asserted in RDATA → all outputs 0 immediately, and after release an AW is accepted normally.

Source files
------------

// File: rtl/hyperbus_pkg.sv
// Shared types and constants for the HyperBus transaction scheduler.
//   hyper_sched_state_t : scheduler FSM states
//   RESP_OKAY/SLVERR    : AXI response codes driven on B and R
//   hyper_cmd_t         : one latched AXI command (address, length, burst, ID, direction)
package hyperbus_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Reserved AXI burst encoding; such a command completes with SLVERR.
    localparam logic [1:0] BURST_RESERVED = 2'b11;

    // Width of the ID field held in a command. The scheduler's ID_WIDTH
    // parameter must not exceed it.
    localparam int unsigned HB_ID_WIDTH = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WDATA,
        ST_WRESP,
        ST_RDATA
    } hyper_sched_state_t;

    typedef struct packed {
        logic [31:0]            addr;
        logic [7:0]             len;
        logic [1:0]             burst;
        logic [HB_ID_WIDTH-1:0] id;
        logic                   write;
    } hyper_cmd_t;

endpackage

// File: rtl/hyperbus_rr_arb2.sv
// Two-way round-robin arbiter between the AXI write-address and
// read-address channels.
//   clk, rst  : clock, asynchronous active-high reset
//   enable    : grants are only issued while the scheduler is idle
//   req_wr/rd : AW / AR valid
//   gnt_wr/rd : one-hot (or zero) grant, combinational from the requests
// A lone request is granted directly. On a tie the channel that was not
// granted last time wins; the very first tie after reset goes to read.
module hyperbus_rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic req_wr,
    input  logic req_rd,
    output logic gnt_wr,
    output logic gnt_rd
);

    logic last_was_write_q;
    logic primed_q;     // set by the first grant; until then a tie favours read
    logic tie_to_wr;

    assign tie_to_wr = primed_q & ~last_was_write_q;

    // NOTE: every combinational output gets a default before any branch so
    // that no path leaves it unassigned and infers a latch.
    always_comb begin
        gnt_wr = 1'b0;
        gnt_rd = 1'b0;
        if (enable) begin
            if (req_wr && req_rd) begin
                gnt_wr = tie_to_wr;
                gnt_rd = ~tie_to_wr;
            end else begin
                gnt_wr = req_wr;
                gnt_rd = req_rd;
            end
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_was_write_q <= 1'b0;
            primed_q         <= 1'b0;
        end else if (gnt_wr || gnt_rd) begin
            last_was_write_q <= gnt_wr;
            primed_q         <= 1'b1;
        end
    end

endmodule

// File: rtl/hyperbus_trans_sched.sv
// HyperBus transaction scheduler: sits between the AXI slave channels and the
// PHY transaction port / TX-RX CDC FIFOs. One command in flight at a time.
//   aw_*/ar_*    : AXI address channels, arbitrated round-robin while idle
//   w_*  -> tx_* : write data gated to the TX FIFO, counted against len
//   rx_* -> r_*  : read data from the RX FIFO, r_last generated from the count
//   b_*          : single write response per write, ID echoed
//   trans_*      : PHY command (address, direction, beat count, burst type, space)
//   trans_error_i: PHY error strobe; makes the current transfer end in SLVERR
//   busy_o       : high whenever a command is being processed
module hyperbus_trans_sched
    import hyperbus_pkg::*;
#(
    parameter int unsigned BURST_WIDTH = 12,
    parameter int unsigned ID_WIDTH    = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,

    input  logic                   aw_valid_i,
    output logic                   aw_ready_o,
    input  logic [31:0]            aw_addr_i,
    input  logic [7:0]             aw_len_i,
    input  logic [1:0]             aw_burst_i,
    input  logic [ID_WIDTH-1:0]    aw_id_i,

    input  logic                   ar_valid_i,
    output logic                   ar_ready_o,
    input  logic [31:0]            ar_addr_i,
    input  logic [7:0]             ar_len_i,
    input  logic [1:0]             ar_burst_i,
    input  logic [ID_WIDTH-1:0]    ar_id_i,

    input  logic                   w_valid_i,
    output logic                   w_ready_o,
    input  logic                   w_last_i,

    output logic                   tx_valid_o,
    input  logic                   tx_ready_i,

    input  logic                   rx_valid_i,
    output logic                   rx_ready_o,

    output logic                   r_valid_o,
    input  logic                   r_ready_i,
    output logic                   r_last_o,
    output logic [ID_WIDTH-1:0]    r_id_o,
    output logic [1:0]             r_resp_o,

    output logic                   b_valid_o,
    input  logic                   b_ready_i,
    output logic [ID_WIDTH-1:0]    b_id_o,
    output logic [1:0]             b_resp_o,

    output logic                   trans_valid_o,
    input  logic                   trans_ready_i,
    output logic [31:0]            trans_address_o,
    output logic                   trans_write_o,
    output logic [BURST_WIDTH-1:0] trans_burst_o,
    output logic                   trans_burst_type_o,
    output logic                   trans_address_space_o,
    input  logic                   trans_error_i,

    output logic                   busy_o
);

    hyper_sched_state_t state_q, state_d;
    hyper_cmd_t         cmd_q;
    logic [7:0]         cnt_q;
    logic               err_q;

    logic gnt_wr, gnt_rd;
    logic cnt_last;
    logic w_beat, r_beat;

    hyperbus_rr_arb2 u_arb (
        .clk    (clk_i),
        .rst    (rst_i),
        .enable (state_q == ST_IDLE),
        .req_wr (aw_valid_i),
        .req_rd (ar_valid_i),
        .gnt_wr (gnt_wr),
        .gnt_rd (gnt_rd)
    );

    // The counter stops on the final beat, so len=255 reaches 255 without wrapping.
    assign cnt_last = (cnt_q == cmd_q.len);
    assign w_beat   = (state_q == ST_WDATA) & w_valid_i & w_ready_o;
    assign r_beat   = (state_q == ST_RDATA) & rx_valid_i & r_ready_i;

    // PHY command fields come straight from the latched command.
    assign trans_address_o       = cmd_q.addr;
    assign trans_write_o         = cmd_q.write;
    assign trans_burst_o         = BURST_WIDTH'(cmd_q.len) + BURST_WIDTH'(1);
    assign trans_burst_type_o    = cmd_q.burst[0];
    assign trans_address_space_o = cmd_q.addr[31];
    assign busy_o                = (state_q != ST_IDLE);

    always_comb begin
        state_d       = state_q;
        aw_ready_o    = 1'b0;
        ar_ready_o    = 1'b0;
        w_ready_o     = 1'b0;
        tx_valid_o    = 1'b0;
        rx_ready_o    = 1'b0;
        r_valid_o     = 1'b0;
        r_last_o      = 1'b0;
        r_id_o        = '0;
        r_resp_o      = RESP_OKAY;
        b_valid_o     = 1'b0;
        b_id_o        = '0;
        b_resp_o      = RESP_OKAY;
        trans_valid_o = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                aw_ready_o = gnt_wr;
                ar_ready_o = gnt_rd;
                if (gnt_wr || gnt_rd) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                trans_valid_o = 1'b1;
                if (trans_ready_i) state_d = cmd_q.write ? ST_WDATA : ST_RDATA;
            end
            ST_WDATA: begin
                // After an error the remaining write beats are drained
                // without reaching the TX FIFO.
                tx_valid_o = w_valid_i & ~err_q;
                w_ready_o  = err_q | tx_ready_i;
                if (w_valid_i && w_ready_o && cnt_last) state_d = ST_WRESP;
            end
            ST_WRESP: begin
                b_valid_o = 1'b1;
                b_id_o    = ID_WIDTH'(cmd_q.id);
                b_resp_o  = err_q ? RESP_SLVERR : RESP_OKAY;
                if (b_ready_i) state_d = ST_IDLE;
            end
            ST_RDATA: begin
                r_valid_o  = rx_valid_i;
                rx_ready_o = r_ready_i;
                r_last_o   = cnt_last & rx_valid_i;
                r_id_o     = rx_valid_i ? ID_WIDTH'(cmd_q.id) : '0;
                r_resp_o   = (rx_valid_i && err_q) ? RESP_SLVERR : RESP_OKAY;
                if (rx_valid_i && r_ready_i && cnt_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                ST_IDLE: begin
                    if (gnt_wr) begin
                        cmd_q <= '{addr: aw_addr_i, len: aw_len_i, burst: aw_burst_i,
                                   id: HB_ID_WIDTH'(aw_id_i), write: 1'b1};
                    end else if (gnt_rd) begin
                        cmd_q <= '{addr: ar_addr_i, len: ar_len_i, burst: ar_burst_i,
                                   id: HB_ID_WIDTH'(ar_id_i), write: 1'b0};
                    end
                end
                ST_ISSUE: begin
                    if (trans_ready_i) begin
                        cnt_q <= '0;
                        err_q <= (cmd_q.burst == BURST_RESERVED);
                    end
                end
                ST_WDATA: begin
                    if (trans_error_i) err_q <= 1'b1;
                    if (w_beat) begin
                        if (w_last_i != cnt_last) err_q <= 1'b1;
                        if (!cnt_last) cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_RDATA: begin
                    if (trans_error_i) err_q <= 1'b1;
                    if (r_beat && !cnt_last) cnt_q <= cnt_q + 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hyperbus_trans_sched.sv
// Directed bench for hyperbus_trans_sched. Inputs change just after a clock
// edge; outputs are sampled 1 ns after the falling edge.
module tb_hyperbus_trans_sched;

    localparam int unsigned BW  = 12;
    localparam int unsigned IDW = 4;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic            aw_valid_i = 1'b0, ar_valid_i = 1'b0;
    logic            aw_ready_o, ar_ready_o;
    logic [31:0]     aw_addr_i = '0, ar_addr_i = '0;
    logic [7:0]      aw_len_i = '0, ar_len_i = '0;
    logic [1:0]      aw_burst_i = 2'b01, ar_burst_i = 2'b01;
    logic [IDW-1:0]  aw_id_i = '0, ar_id_i = '0;
    logic            w_valid_i = 1'b0, w_last_i = 1'b0, w_ready_o;
    logic            tx_valid_o, tx_ready_i = 1'b0;
    logic            rx_valid_i = 1'b0, rx_ready_o;
    logic            r_valid_o, r_ready_i = 1'b0, r_last_o;
    logic [IDW-1:0]  r_id_o;
    logic [1:0]      r_resp_o;
    logic            b_valid_o, b_ready_i = 1'b0;
    logic [IDW-1:0]  b_id_o;
    logic [1:0]      b_resp_o;
    logic            trans_valid_o, trans_ready_i = 1'b0;
    logic [31:0]     trans_address_o;
    logic            trans_write_o;
    logic [BW-1:0]   trans_burst_o;
    logic            trans_burst_type_o, trans_address_space_o;
    logic            trans_error_i = 1'b0;
    logic            busy_o;

    int n_tests = 0;
    int n_fail  = 0;
    int tx_beats;

    always #5 clk_i = ~clk_i;

    hyperbus_trans_sched #(.BURST_WIDTH(BW), .ID_WIDTH(IDW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_addr_i(aw_addr_i),
        .aw_len_i(aw_len_i), .aw_burst_i(aw_burst_i), .aw_id_i(aw_id_i),
        .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_addr_i(ar_addr_i),
        .ar_len_i(ar_len_i), .ar_burst_i(ar_burst_i), .ar_id_i(ar_id_i),
        .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_last_i(w_last_i),
        .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
        .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_last_o(r_last_o),
        .r_id_o(r_id_o), .r_resp_o(r_resp_o),
        .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o), .b_resp_o(b_resp_o),
        .trans_valid_o(trans_valid_o), .trans_ready_i(trans_ready_i),
        .trans_address_o(trans_address_o), .trans_write_o(trans_write_o),
        .trans_burst_o(trans_burst_o), .trans_burst_type_o(trans_burst_type_o),
        .trans_address_space_o(trans_address_space_o), .trans_error_i(trans_error_i),
        .busy_o(busy_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_aw(input logic [31:0] addr, input logic [7:0] len, input logic [IDW-1:0] id);
        @(negedge clk_i);
        aw_addr_i = addr; aw_len_i = len; aw_burst_i = 2'b01; aw_id_i = id; aw_valid_i = 1'b1;
        #1 check("aw_ready", aw_ready_o, 1'b1);
        @(posedge clk_i); #1 aw_valid_i = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] addr, input logic [7:0] len, input logic [IDW-1:0] id);
        @(negedge clk_i);
        ar_addr_i = addr; ar_len_i = len; ar_burst_i = 2'b01; ar_id_i = id; ar_valid_i = 1'b1;
        #1 check("ar_ready", ar_ready_o, 1'b1);
        @(posedge clk_i); #1 ar_valid_i = 1'b0;
    endtask

    // Both address channels request together; exp_wr says which must win.
    task automatic tie(input logic exp_wr, input string tag);
        @(negedge clk_i);
        aw_valid_i = 1'b1; ar_valid_i = 1'b1;
        #1;
        check({tag, "_aw_ready"}, aw_ready_o, exp_wr);
        check({tag, "_ar_ready"}, ar_ready_o, !exp_wr);
        @(posedge clk_i); #1 aw_valid_i = 1'b0; ar_valid_i = 1'b0;
    endtask

    task automatic do_trans(input string tag, input logic exp_wr, input logic [31:0] exp_addr,
                            input logic [BW-1:0] exp_burst, input logic exp_space);
        int n = 0;
        @(negedge clk_i); #1;
        while (!trans_valid_o && n < 20) begin
            @(negedge clk_i); #1; n++;
        end
        check({tag, "_trans_valid"}, trans_valid_o, 1'b1);
        check({tag, "_trans_write"}, trans_write_o, exp_wr);
        check({tag, "_trans_addr"}, trans_address_o, exp_addr);
        check({tag, "_trans_burst"}, trans_burst_o, exp_burst);
        check({tag, "_trans_space"}, trans_address_space_o, exp_space);
        check({tag, "_trans_type"}, trans_burst_type_o, 1'b1);
        trans_ready_i = 1'b1;
        @(posedge clk_i); #1 trans_ready_i = 1'b0;
    endtask

    task automatic write_beat(input string tag, input logic last, input logic tx_rdy, input logic exp_tx);
        @(negedge clk_i);
        w_valid_i = 1'b1; w_last_i = last; tx_ready_i = tx_rdy;
        #1;
        check({tag, "_tx_valid"}, tx_valid_o, exp_tx);
        check({tag, "_w_ready"}, w_ready_o, 1'b1);
        if (tx_valid_o && tx_ready_i) tx_beats++;
        @(posedge clk_i); #1 w_valid_i = 1'b0; w_last_i = 1'b0; tx_ready_i = 1'b0;
    endtask

    task automatic read_beat(input string tag, input logic exp_last, input logic [IDW-1:0] exp_id);
        @(negedge clk_i);
        rx_valid_i = 1'b1; r_ready_i = 1'b1;
        #1;
        check({tag, "_r_valid"}, r_valid_o, 1'b1);
        check({tag, "_r_last"}, r_last_o, exp_last);
        check({tag, "_r_id"}, r_id_o, exp_id);
        check({tag, "_r_resp"}, r_resp_o, 2'b00);
        check({tag, "_rx_ready"}, rx_ready_o, 1'b1);
        @(posedge clk_i); #1 rx_valid_i = 1'b0; r_ready_i = 1'b0;
    endtask

    task automatic bresp(input string tag, input logic [IDW-1:0] exp_id, input logic [1:0] exp_resp);
        int n = 0;
        @(negedge clk_i); #1;
        while (!b_valid_o && n < 20) begin
            @(negedge clk_i); #1; n++;
        end
        check({tag, "_b_valid"}, b_valid_o, 1'b1);
        check({tag, "_b_id"}, b_id_o, exp_id);
        check({tag, "_b_resp"}, b_resp_o, exp_resp);
        b_ready_i = 1'b1;
        @(posedge clk_i); #1 b_ready_i = 1'b0;
        @(negedge clk_i); #1 check({tag, "_idle"}, busy_o, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;

        // Reset state
        repeat (2) @(negedge clk_i);
        #1;
        check("rst_busy", busy_o, 1'b0);
        check("rst_trans_valid", trans_valid_o, 1'b0);
        check("rst_b_valid", b_valid_o, 1'b0);
        check("rst_r_valid", r_valid_o, 1'b0);
        check("rst_w_ready", w_ready_o, 1'b0);
        check("rst_aw_ready", aw_ready_o, 1'b0);
        check("rst_trans_addr", trans_address_o, 32'h0);
        @(posedge clk_i); #1 rst_i = 1'b0;

        // Ties: read first after reset, then alternate
        aw_addr_i = 32'h0000_0100; aw_len_i = 8'd0; aw_id_i = 4'd1;
        ar_addr_i = 32'h0000_0200; ar_len_i = 8'd0; ar_id_i = 4'd2;
        tie(1'b0, "tie1");
        do_trans("tie1", 1'b0, 32'h0000_0200, 12'd1, 1'b0);
        read_beat("tie1", 1'b1, 4'd2);
        tie(1'b1, "tie2");
        do_trans("tie2", 1'b1, 32'h0000_0100, 12'd1, 1'b0);
        write_beat("tie2", 1'b1, 1'b1, 1'b1);
        bresp("tie2", 4'd1, 2'b00);
        tie(1'b0, "tie3");
        do_trans("tie3", 1'b0, 32'h0000_0200, 12'd1, 1'b0);
        read_beat("tie3", 1'b1, 4'd2);

        // Single write of 4 beats
        tx_beats = 0;
        send_aw(32'h0000_1000, 8'd3, 4'd5);
        do_trans("wr4", 1'b1, 32'h0000_1000, 12'd4, 1'b0);
        for (int i = 0; i < 4; i++) write_beat("wr4", (i == 3), 1'b1, 1'b1);
        bresp("wr4", 4'd5, 2'b00);
        check("wr4_tx_beats", tx_beats, 4);

        // Single-beat read from register space
        send_ar(32'h8000_0004, 8'd0, 4'd6);
        do_trans("rd1", 1'b0, 32'h8000_0004, 12'd1, 1'b1);
        read_beat("rd1", 1'b1, 4'd6);
        @(negedge clk_i); #1 check("rd1_idle", busy_o, 1'b0);

        // PHY error during an 8-beat write: beats 3..7 drained, SLVERR
        tx_beats = 0;
        send_aw(32'h0000_2000, 8'd7, 4'd7);
        do_trans("wrerr", 1'b1, 32'h0000_2000, 12'd8, 1'b0);
        for (int i = 0; i < 3; i++) write_beat("wrerr_pre", 1'b0, 1'b1, 1'b1);
        @(negedge clk_i); trans_error_i = 1'b1;
        @(posedge clk_i); #1 trans_error_i = 1'b0;
        for (int i = 3; i < 8; i++) write_beat("wrerr_drain", (i == 7), 1'b0, 1'b0);
        bresp("wrerr", 4'd7, 2'b10);
        check("wrerr_tx_beats", tx_beats, 3);

        // 4-beat read with r_ready toggling every cycle
        send_ar(32'h0000_3000, 8'd3, 4'd8);
        do_trans("rdtog", 1'b0, 32'h0000_3000, 12'd4, 1'b0);
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_i);
            rx_valid_i = 1'b1; r_ready_i = k[0];
            #1;
            check("rdtog_r_valid", r_valid_o, 1'b1);
            check("rdtog_r_last", r_last_o, (acc == 3));
            check("rdtog_busy", busy_o, 1'b1);
            if (r_ready_i) acc++;
        end
        @(posedge clk_i); #1 rx_valid_i = 1'b0; r_ready_i = 1'b0;
        check("rdtog_accepted", acc, 4);
        @(negedge clk_i); #1 check("rdtog_idle", busy_o, 1'b0);

        // Reset in the middle of a read, then a normal write
        send_ar(32'h0000_4000, 8'd7, 4'd9);
        do_trans("rdrst", 1'b0, 32'h0000_4000, 12'd8, 1'b0);
        read_beat("rdrst", 1'b0, 4'd9);
        read_beat("rdrst", 1'b0, 4'd9);
        @(negedge clk_i);
        rx_valid_i = 1'b1; r_ready_i = 1'b1;
        #1 check("rdrst_pre_r_valid", r_valid_o, 1'b1);
        rst_i = 1'b1;
        #1;
        check("rdrst_r_valid", r_valid_o, 1'b0);
        check("rdrst_rx_ready", rx_ready_o, 1'b0);
        check("rdrst_busy", busy_o, 1'b0);
        check("rdrst_trans_addr", trans_address_o, 32'h0);
        rx_valid_i = 1'b0; r_ready_i = 1'b0;
        @(posedge clk_i); #1 rst_i = 1'b0;
        tx_beats = 0;
        send_aw(32'h0000_5000, 8'd1, 4'd10);
        do_trans("postrst", 1'b1, 32'h0000_5000, 12'd2, 1'b0);
        write_beat("postrst", 1'b0, 1'b1, 1'b1);
        write_beat("postrst", 1'b1, 1'b1, 1'b1);
        bresp("postrst", 4'd10, 2'b00);
        check("postrst_tx_beats", tx_beats, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
